// File: rtl/phase_sequencer.sv
// Purpose: five-phase strobe generator (IF/ID/ALU/MEM/RB_BR) with HALT/IRQ parking and retired-instruction count.
// Latency: every output is a flop loaded from the next-state decode, so it reflects the state of the current cycle.
// Backpressure: stall holds the last MEM sub-cycle only when PHASE_SEQ_STALL_EN is defined; otherwise stall is ignored.
module phase_sequencer #(
    parameter int PHASE_CYCLES = 2,
    parameter int COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         branch_opcode,
    input  logic               interrupt,
    input  logic               irq_ret,
    input  logic               resume,
    input  logic               stall,
    output logic               IF_clk,
    output logic               ID_clk,
    output logic               ALU_clk,
    output logic               MEM_clk,
    output logic               RB_BR_clk,
    output logic [2:0]         phase,
    output logic               halted,
    output logic               irq_ack,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int SUB_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_ALU  = 3'd2,
        ST_MEM  = 3'd3,
        ST_RB   = 3'd4,
        ST_HALT = 3'd5,
        ST_IRQ  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    // Low for the first cycle after reset so the sequence starts at IF
    // sub-cycle 0 with the IF strobe visible, instead of skipping past it.
    logic               started_q, started_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [4:0]         strobe_q, strobe_d;
    logic [2:0]         phase_q, phase_d;
    logic               halted_q, halted_d;
    logic               irq_ack_q, irq_ack_d;
    logic               sub_last;
    logic               mem_hold;

    assign sub_last = (sub_q == SUB_LAST);

`ifdef PHASE_SEQ_STALL_EN
    assign mem_hold = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign mem_hold     = 1'b0;
`endif

    // Next-state: phase/sub-cycle advance, RB exit decision and HALT/IRQ exits.
    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        started_d = 1'b1;
        count_d   = count_q;
        if (!started_q) begin
            state_d = ST_IF;
            sub_d   = '0;
        end else begin
            case (state_q)
                ST_IF, ST_ID, ST_ALU: begin
                    if (sub_last) begin
                        state_d = state_t'(state_q + 3'd1);
                        sub_d   = '0;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                ST_MEM: begin
                    if (sub_last) begin
                        if (!mem_hold) begin
                            state_d = ST_RB;
                            sub_d   = '0;
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                ST_RB: begin
                    if (sub_last) begin
                        count_d = count_q + COUNT_W'(1);
                        sub_d   = '0;
                        if (interrupt) begin
                            state_d = ST_IRQ;
                        end else if (branch_opcode == 3'b000) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_IF;
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                ST_HALT: begin
                    sub_d = '0;
                    if (resume) begin
                        state_d = ST_IF;
                    end
                end
                ST_IRQ: begin
                    sub_d = '0;
                    if (irq_ret) begin
                        state_d = ST_IF;
                    end
                end
                default: begin
                    state_d = ST_IF;
                    sub_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with the state they describe.
    // A hold in the last MEM sub-cycle never has sub_d==0, so the MEM strobe is not re-pulsed.
    always_comb begin
        strobe_d  = 5'b00000;
        phase_d   = 3'(state_d);
        halted_d  = (state_d == ST_HALT);
        irq_ack_d = (state_d == ST_IRQ);
        if (sub_d == '0) begin
            case (state_d)
                ST_IF:   strobe_d = 5'b10000;
                ST_ID:   strobe_d = 5'b01000;
                ST_ALU:  strobe_d = 5'b00100;
                ST_MEM:  strobe_d = 5'b00010;
                ST_RB:   strobe_d = 5'b00001;
                default: strobe_d = 5'b00000;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IF;
            sub_q     <= '0;
            started_q <= 1'b0;
            count_q   <= '0;
            strobe_q  <= 5'b00000;
            phase_q   <= 3'd0;
            halted_q  <= 1'b0;
            irq_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            started_q <= started_d;
            count_q   <= count_d;
            strobe_q  <= strobe_d;
            phase_q   <= phase_d;
            halted_q  <= halted_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign IF_clk      = strobe_q[4];
    assign ID_clk      = strobe_q[3];
    assign ALU_clk     = strobe_q[2];
    assign MEM_clk     = strobe_q[1];
    assign RB_BR_clk   = strobe_q[0];
    assign phase       = phase_q;
    assign halted      = halted_q;
    assign irq_ack     = irq_ack_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: basic order, halt/resume, interrupt priority, stall, mid-run reset, count wrap.
// Cycle c starts at the rising edge that ends cycle c-1; outputs are sampled and inputs driven 1 time unit later.
// A second instance with COUNT_W=4 shares all stimulus and is used for the wrap check.
module tb_phase_sequencer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  branch_opcode;
    logic        interrupt;
    logic        irq_ret;
    logic        resume;
    logic        stall;
    logic        if_clk, id_clk, alu_clk, mem_clk, rb_clk;
    logic [2:0]  phase;
    logic        halted;
    logic        irq_ack;
    logic [31:0] instr_count;
    logic        w_if, w_id, w_alu, w_mem, w_rb;
    logic [2:0]  w_phase;
    logic        w_halted, w_irq_ack;
    logic [3:0]  w_count;

    int tests;
    int fails;
    int cyc;

    phase_sequencer #(.PHASE_CYCLES(2), .COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .branch_opcode(branch_opcode),
        .interrupt(interrupt), .irq_ret(irq_ret), .resume(resume), .stall(stall),
        .IF_clk(if_clk), .ID_clk(id_clk), .ALU_clk(alu_clk), .MEM_clk(mem_clk),
        .RB_BR_clk(rb_clk), .phase(phase), .halted(halted), .irq_ack(irq_ack),
        .instr_count(instr_count)
    );

    phase_sequencer #(.PHASE_CYCLES(2), .COUNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .branch_opcode(branch_opcode),
        .interrupt(interrupt), .irq_ret(irq_ret), .resume(resume), .stall(stall),
        .IF_clk(w_if), .ID_clk(w_id), .ALU_clk(w_alu), .MEM_clk(w_mem),
        .RB_BR_clk(w_rb), .phase(w_phase), .halted(w_halted), .irq_ack(w_irq_ack),
        .instr_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] strobes();
        return {if_clk, id_clk, alu_clk, mem_clk, rb_clk};
    endfunction

    // Expected strobe vector for an unstalled run, PHASE_CYCLES=2.
    function automatic logic [4:0] nominal(input int c);
        case (c % 10)
            0:       return 5'b10000;
            2:       return 5'b01000;
            4:       return 5'b00100;
            6:       return 5'b00010;
            8:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Expected strobes with stall high in cycles 7..11.
    function automatic logic [4:0] stall_exp(input int c);
`ifdef PHASE_SEQ_STALL_EN
        if (c <= 6)  return nominal(c);
        if (c == 13) return 5'b00001;
        if (c == 15) return 5'b10000;
        return 5'b00000;
`else
        return nominal(c);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_strb"},    32'(strobes()), 32'd0);
        chk({tag, "_phase"},   32'(phase), 32'd0);
        chk({tag, "_halted"},  32'(halted), 32'd0);
        chk({tag, "_irqack"},  32'(irq_ack), 32'd0);
        chk({tag, "_count"},   instr_count, 32'd0);
    endtask

    // Holds reset for two edges, then releases it; returns sampled in cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = -1;
        tick();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        rst_n = 1'b0;
        branch_opcode = 3'b001;
        interrupt = 1'b0;
        irq_ret = 1'b0;
        resume = 1'b0;
        stall = 1'b0;

        // Reset state, then basic sequence.
        tick();
        tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc = -1;
        tick();
        for (int c = 0; c <= 10; c++) begin
            run_to(c);
            chk("basic_strb", 32'(strobes()), 32'(nominal(c)));
            if (c == 3) chk("basic_phase3", 32'(phase), 32'd1);
            if (c == 9) chk("basic_phase9", 32'(phase), 32'd4);
        end
        chk("basic_count10", instr_count, 32'd1);

        // Halt and resume; resume outside HALT must be ignored.
        do_reset();
        run_to(4);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_ignored", 32'(phase), 32'd2);
        run_to(9);
        branch_opcode = 3'b000;
        tick();
        branch_opcode = 3'b001;
        chk("halt_halted10", 32'(halted), 32'd1);
        chk("halt_phase10", 32'(phase), 32'd5);
        chk("halt_strb10", 32'(strobes()), 32'd0);
        run_to(19);
        chk("halt_held19", 32'(halted), 32'd1);
        chk("halt_strb19", 32'(strobes()), 32'd0);
        run_to(20);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_if21", 32'(if_clk), 32'd1);
        chk("resume_halted21", 32'(halted), 32'd0);
        chk("resume_phase21", 32'(phase), 32'd0);

        // Interrupt beats halt opcode.
        do_reset();
        run_to(9);
        interrupt = 1'b1;
        branch_opcode = 3'b000;
        tick();
        interrupt = 1'b0;
        branch_opcode = 3'b001;
        chk("irq_ack10", 32'(irq_ack), 32'd1);
        chk("irq_halted10", 32'(halted), 32'd0);
        chk("irq_phase10", 32'(phase), 32'd6);
        chk("irq_strb10", 32'(strobes()), 32'd0);
        run_to(12);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("irq_resume_ignored", 32'(irq_ack), 32'd1);
        run_to(14);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        chk("irq_if15", 32'(if_clk), 32'd1);
        chk("irq_ack15", 32'(irq_ack), 32'd0);
        chk("irq_count15", instr_count, 32'd1);

        // Stall in cycles 7..11.
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            run_to(c);
            stall = (c >= 7 && c <= 11);
            chk("stall_strb", 32'(strobes()), 32'(stall_exp(c)));
        end
        stall = 1'b0;

        // Reset low for cycle 5 only, from a HALT state with a nonzero count.
        do_reset();
        run_to(9);
        branch_opcode = 3'b000;
        tick();
        branch_opcode = 3'b001;
        run_to(12);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_vals("midrst_halt");
        do_reset();
        run_to(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_vals("midrst");
        tick();
        chk("midrst_if7", 32'(if_clk), 32'd1);
        tick();
        chk("midrst_strb8", 32'(strobes()), 32'd0);
        tick();
        chk("midrst_id9", 32'(id_clk), 32'd1);

        // Counter wrap on the 4-bit instance.
        do_reset();
        run_to(150);
        chk("wrap_w15", 32'(w_count), 32'd15);
        run_to(160);
        chk("wrap_w0", 32'(w_count), 32'd0);
        chk("wrap_main16", instr_count, 32'd16);
        run_to(170);
        chk("wrap_w1", 32'(w_count), 32'd1);
        chk("wrap_if170", 32'(w_if), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Single-clock phase generator that drives the control unit's five phase strobes: `IF_clk`, `ID_clk`, `ALU_clk`, `MEM_clk` and `RB_BR_clk`. It sits directly upstream of the control unit. Each instruction is one pass through five phases. The block closes the loop on the control unit's `branch_opcode` halt code and its `interrupt` flag by parking the sequence in a HALT or IRQ state. It also counts retired instructions.

## Interface
- `PHASE_CYCLES`, default 2: clk cycles per phase; legal range ≥ 2.
- `COUNT_W`, default 32: width of `instr_count`.

- `clk`  in  1  system clock; all flops on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `branch_opcode`  in  3  from the control unit; `3'b000` means halt.
- `interrupt`  in  1  from the control unit; MTC interrupt request.
- `irq_ret`  in  1  interrupt service done; used only in IRQ.
- `resume`  in  1  restart request; used only in HALT.
- `stall`  in  1  memory wait request; used only in MEM.
- `IF_clk`, `ID_clk`, `ALU_clk`, `MEM_clk`, `RB_BR_clk`  out  1 each  registered phase strobes.
- `phase`  out  3  current state: IF=0, ID=1, ALU=2, MEM=3, RB=4, HALT=5, IRQ=6.
- `halted`  out  1  high while in HALT.
- `irq_ack`  out  1  high while in IRQ.
- `instr_count`  out  COUNT_W  number of completed RB phases.

## Operation
- States are IF, ID, ALU, MEM, RB, HALT and IRQ.
- A sub-counter runs from 0 to PHASE_CYCLES-1 within each phase.
- A phase's strobe is high only in sub-cycle 0 of that phase, which gives one rising edge per phase. At most one strobe is high in any cycle.
- Normal order is IF→ID→ALU→MEM→RB, advancing after the last sub-cycle.
- In the last MEM sub-cycle, `stall`=1 holds MEM in that sub-cycle. The strobe is not re-pulsed. See Configuration.
- In the last RB sub-cycle, the block samples its inputs and chooses the next state:
  - `interrupt`=1 → IRQ.
  - Otherwise `branch_opcode`==3'b000 → HALT.
  - Otherwise → IF.
  - If both are high, interrupt wins.
- Leaving RB in any direction increments `instr_count` by 1, modulo 2^COUNT_W (wraps silently).
- HALT: all strobes are 0 and `halted`=1. `resume`=1 → IF at sub-cycle 0 in the next cycle.
- IRQ: all strobes are 0 and `irq_ack`=1. `irq_ret`=1 → IF in the next cycle.
- Inputs are ignored in every state that does not use them: `resume` outside HALT, `irq_ret` outside IRQ, `stall` outside the last MEM sub-cycle.

## Timing
- All outputs are registered; no combinational path runs from any input to any output.
- Reset values:
  - All strobes 0, `halted` 0, `irq_ack` 0, `instr_count` 0.
  - `phase` 0; the state register is IF with sub-counter 0.
- Cycle 0 is the first cycle after `rst_n` is sampled high. `IF_clk` is high in cycle 0.
- The instruction period is 5×PHASE_CYCLES cycles with no stall.
- The strobe for phase k (IF=0 … RB=4) rises at cycle k×PHASE_CYCLES.
- Entry into HALT or IRQ takes effect in the cycle immediately after the last RB sub-cycle. `halted`/`irq_ack` rise in that cycle.
- Exit: `resume` or `irq_ret` sampled in cycle n → `IF_clk` high in cycle n+1, and `halted`/`irq_ack` low in cycle n+1.
- Reset mid-operation: `rst_n` low in cycle n → in cycle n+1 all outputs hold their reset values, regardless of state.

## Configuration
- `PHASE_SEQ_STALL_EN` defined: the `stall` input extends the MEM phase as described above.
- `PHASE_SEQ_STALL_EN` undefined:
  - `stall` is ignored; the port still exists.
  - MEM always lasts exactly PHASE_CYCLES cycles.

## Test plan
- Basic sequence (PHASE_CYCLES=2): release reset.
  - Strobes must be high at cycle 0 (IF), 2 (ID), 4 (ALU), 6 (MEM), 8 (RB_BR) and 10 (IF); every other cycle has all strobes 0.
  - `instr_count` must be 1 at cycle 10.
- Halt and resume: `branch_opcode`=3'b000 in cycle 9.
  - `halted`=1 and `phase`=5 from cycle 10, with no strobes.
  - `resume` pulsed in cycle 20 → `IF_clk` high in cycle 21 and `halted`=0.
- Interrupt priority: `interrupt`=1 and `branch_opcode`=000 both in cycle 9.
  - `irq_ack`=1 from cycle 10; `halted` stays 0.
  - `irq_ret` in cycle 14 → `IF_clk` high in cycle 15.
- Stall: `stall`=1 in cycles 7–11, with the macro defined.
  - `RB_BR_clk` high in cycle 13; `MEM_clk` pulses only once, at cycle 6.
  - Repeat with the macro undefined → `RB_BR_clk` high in cycle 8.
- Reset mid-phase: `rst_n`=0 in cycle 5 only.
  - Cycle 6 shows all outputs at reset values.
  - `IF_clk` high in cycle 7.
- Counter wrap: COUNT_W=4, run 16 uninterrupted instructions → `instr_count` returns to 0 and then counts 1 after the 17th.
